instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: issues one line request at a time to the I-cache
// and buffers returned bundles, tagged with their PC, in a small FIFO for decode.
module instruction_fetch_unit #(
    parameter int NFU = 2,
    parameter int PHYSICAL_ADDRESS_LENGTH = 56,
    parameter logic [PHYSICAL_ADDRESS_LENGTH-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic [PHYSICAL_ADDRESS_LENGTH-1:0] icAddress,
    output logic                               icDoFetch,
    input  logic                               icDoneFetch,
    input  logic [NFU*32-1:0]                  icData,
    input  logic                               icMissed,
    input  logic                               redirectValid,
    input  logic [PHYSICAL_ADDRESS_LENGTH-1:0] redirectPc,
    output logic                               bundleValid,
    output logic [NFU*32-1:0]                  bundleData,
    output logic [PHYSICAL_ADDRESS_LENGTH-1:0] bundlePc,
    input  logic                               bundleReady
);
    localparam int PAL = PHYSICAL_ADDRESS_LENGTH;
    localparam int BW  = NFU * 32;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [PAL-1:0] STRIDE    = PAL'(NFU * 4);
    localparam logic [PAL-1:0] LINE_MASK = ~(STRIDE - PAL'(1));

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state_reg;
    logic [PAL-1:0]  fetch_pc_reg;
    logic            do_fetch_reg;
    logic            discard_reg;

    logic [BW-1:0]   data_mem [FIFO_DEPTH];
    logic [PAL-1:0]  pc_mem   [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;
    logic            has_space;
    logic [FIFO_DEPTH-1:0] entry_we;

    // A redirect flushes the buffer, so it overrides both a pop and a push in the same cycle.
    always_comb begin
        pop        = (count_reg != '0) && bundleReady && !redirectValid;
        push       = (state_reg == WAIT) && icDoneFetch && !icMissed && !discard_reg && !redirectValid;
        count_next = count_reg + CW'(push) - CW'(pop);
        has_space  = count_next < CW'(FIFO_DEPTH);
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirectValid) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (entry_we[i]) begin
                    data_mem[i] <= icData;
                    pc_mem[i]   <= fetch_pc_reg;
                end
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            do_fetch_reg <= 1'b0;
            discard_reg  <= 1'b0;
        end else if (redirectValid) begin
            fetch_pc_reg <= redirectPc & LINE_MASK;
            // Once the strobe has gone out the cache owes us a response, which must be swallowed.
            case (state_reg)
                IDLE: begin
                    state_reg    <= REQ;
                    do_fetch_reg <= 1'b1;
                    discard_reg  <= 1'b0;
                end
                REQ: begin
                    state_reg    <= WAIT;
                    do_fetch_reg <= 1'b0;
                    discard_reg  <= 1'b1;
                end
                WAIT: begin
                    if (icDoneFetch) begin
                        state_reg    <= REQ;
                        do_fetch_reg <= 1'b1;
                        discard_reg  <= 1'b0;
                    end else begin
                        state_reg    <= WAIT;
                        do_fetch_reg <= 1'b0;
                        discard_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    do_fetch_reg <= 1'b0;
                    discard_reg  <= 1'b0;
                end
            endcase
        end else begin
            case (state_reg)
                IDLE: begin
                    if (count_reg < CW'(FIFO_DEPTH)) begin
                        state_reg    <= REQ;
                        do_fetch_reg <= 1'b1;
                    end
                end
                REQ: begin
                    state_reg    <= WAIT;
                    do_fetch_reg <= 1'b0;
                end
                WAIT: begin
                    if (icDoneFetch) begin
                        discard_reg <= 1'b0;
                        if (push) fetch_pc_reg <= fetch_pc_reg + STRIDE;
                        if (has_space) begin
                            state_reg    <= REQ;
                            do_fetch_reg <= 1'b1;
                        end else begin
                            state_reg    <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    do_fetch_reg <= 1'b0;
                    discard_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign icAddress   = fetch_pc_reg;
    assign icDoFetch   = do_fetch_reg;
    assign bundleValid = count_reg != '0;
    assign bundleData  = bundleValid ? data_mem[rd_ptr_reg] : '0;
    assign bundlePc    = bundleValid ? pc_mem[rd_ptr_reg] : '0;

endmodule
